// File: rtl/ecc_serial_driver_pkg.sv
// ecc_serial_driver_pkg
//   Shared constants and types for the bit-serial ECC scalar-multiplication
//   path (driver, wrapper, core): operand storage width, mode encodings,
//   per-mode "length minus one" values and the bit-counter width.
package ecc_serial_driver_pkg;

  localparam int ECC_MAX_BITS = 256;
  localparam int MAX_REG      = 9;

  typedef enum logic [1:0] {
    BITS32  = 2'b00,
    BITS64  = 2'b01,
    BITS128 = 2'b10,
    BITS256 = 2'b11
  } mode_e;

  localparam logic [MAX_REG-1:0] LEN32_M1  = 9'd31;
  localparam logic [MAX_REG-1:0] LEN64_M1  = 9'd63;
  localparam logic [MAX_REG-1:0] LEN128_M1 = 9'd127;
  localparam logic [MAX_REG-1:0] LEN256_M1 = 9'd255;

  typedef enum logic [2:0] {
    IDLE,
    MP_HDR,
    MODE_TX,
    MP_TX,
    GAP,
    NP_HDR,
    NP_TX
  } state_e;

  // Index of the first (most significant) transmitted bit for a mode.
  function automatic logic [MAX_REG-1:0] len_m1(input logic [1:0] md);
    logic [MAX_REG-1:0] r;
    unique case (md)
      BITS32:  r = LEN32_M1;
      BITS64:  r = LEN64_M1;
      BITS128: r = LEN128_M1;
      default: r = LEN256_M1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ecc_piso_bank.sv
// ecc_piso_bank
//   Parallel-load bank of K words. The words are captured on load and then
//   read out one bit per word, the bit chosen by an external down-counting
//   index, so the stream is MSB first.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load       capture din into the bank
//   din        K words of W bits
//   idx        bit position presented on dout
//   dout       bit idx of each stored word
module ecc_piso_bank #(
  parameter int K  = 6,
  parameter int W  = 256,
  parameter int IW = $clog2(W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [K-1:0][W-1:0]  din,
  input  logic [IW-1:0]        idx,
  output logic [K-1:0]         dout
);

  logic [K-1:0][W-1:0] word_q, word_d;

  always_comb begin
    word_d = load ? din : word_q;
  end

  // NOTE: the operand store is reset like any other flop: the downstream
  // block shares rst, so a cleared bank keeps the abandoned job unobservable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word_q <= '0;
    else      word_q <= word_d;
  end

  always_comb begin
    for (int k = 0; k < K; k++) dout[k] = word_q[k][idx];
  end

endmodule

// File: rtl/ecc_serial_driver.sv
// ecc_serial_driver
//   Accepts a parallel mP job and then a parallel nP job over valid/ready
//   handshakes and replays them as the bit-serial start-pulse / mode /
//   operand protocol of the ECC scalar-multiplication wrapper.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   mp_req/mp_ready        mP job handshake (mode, a, b, prime, Px, Py, m)
//   np_req/np_ready        nP job handshake (nPx, nPy)
//   o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m   serial mP
//   o_nP_valid, o_nPx, o_nPy                                    serial nP
//   busy                   high whenever the FSM is not IDLE
//   o_err                  one-cycle reject pulse from the range check
// Build option:
//   ECC_DRV_RANGE_CHECK_EN  rejects mP jobs with any of a/b/Px/Py >= prime
//                           or prime == 0; without it o_err is tied low.
module ecc_serial_driver
  import ecc_serial_driver_pkg::*;
#(
  parameter int MAX_BITS = ECC_MAX_BITS,
  parameter int NP_GAP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mp_req,
  output logic                mp_ready,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic [MAX_BITS-1:0] prime,
  input  logic [MAX_BITS-1:0] Px,
  input  logic [MAX_BITS-1:0] Py,
  input  logic [MAX_BITS-1:0] m,
  input  logic                np_req,
  output logic                np_ready,
  input  logic [MAX_BITS-1:0] nPx,
  input  logic [MAX_BITS-1:0] nPy,
  output logic                o_m_P_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nP_valid,
  output logic                o_nPx,
  output logic                o_nPy,
  output logic                busy,
  output logic                o_err
);

  localparam int IW = $clog2(MAX_BITS);

  state_e             state_q, state_d;
  logic [MAX_REG-1:0] cnt_q, cnt_d;
  logic               mp_sent_q, mp_sent_d;
  logic [1:0]         mode_q, mode_d;
  logic               mp_load, np_load, mp_accept, range_err;
  logic [5:0]         mp_bits, mp_out_q, mp_out_d;
  logic [1:0]         np_bits, np_out_q, np_out_d;
  logic               mp_valid_q, mp_valid_d, np_valid_q, np_valid_d;
  logic               mode_out_q, mode_out_d;

  ecc_piso_bank #(.K(6), .W(MAX_BITS)) u_mp_bank (
    .clk  (clk),
    .rst  (rst),
    .load (mp_load),
    .din  ({a, b, prime, Px, Py, m}),
    .idx  (cnt_d[IW-1:0]),
    .dout (mp_bits)
  );

  ecc_piso_bank #(.K(2), .W(MAX_BITS)) u_np_bank (
    .clk  (clk),
    .rst  (rst),
    .load (np_load),
    .din  ({nPx, nPy}),
    .idx  (cnt_d[IW-1:0]),
    .dout (np_bits)
  );

  assign mp_ready  = (state_q == IDLE) && !mp_sent_q;
  assign np_ready  = (state_q == IDLE) && mp_sent_q;
  assign busy      = (state_q != IDLE);
  assign mp_accept = mp_req && mp_ready;

`ifdef ECC_DRV_RANGE_CHECK_EN
  logic [MAX_BITS-1:0] mask, p_m;
  logic                err_q;

  // Compares against the mode on the input pins: the check happens in the
  // acceptance cycle, before mode is latched.
  always_comb begin
    mask      = {MAX_BITS{1'b1}} >> (MAX_BITS - 1 - int'(len_m1(mode)));
    p_m       = prime & mask;
    range_err = (p_m == '0) || ((a & mask) >= p_m) || ((b & mask) >= p_m) ||
                ((Px & mask) >= p_m) || ((Py & mask) >= p_m);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= mp_accept && range_err;
  end

  assign o_err = err_q;
`else
  assign range_err = 1'b0;
  assign o_err     = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mp_sent_d = mp_sent_q;
    mode_d    = mode_q;
    mp_load   = 1'b0;
    np_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mp_accept && !range_err) begin
          mp_load = 1'b1;
          mode_d  = mode;
          state_d = MP_HDR;
        end else if (np_req && np_ready) begin
          np_load = 1'b1;
          state_d = NP_HDR;
        end
      end
      MP_HDR: begin
        state_d = MODE_TX;
        cnt_d   = MAX_REG'(1);
      end
      MODE_TX: begin
        if (cnt_q == '0) begin
          state_d = MP_TX;
          cnt_d   = len_m1(mode_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MP_TX: begin
        if (cnt_q == '0) begin
          state_d   = GAP;
          cnt_d     = MAX_REG'(NP_GAP - 1);
          mp_sent_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      NP_HDR: begin
        state_d = NP_TX;
        cnt_d   = len_m1(mode_q);
      end
      NP_TX: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          mp_sent_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that the registered
    // serial lines line up with the state they belong to.
    mp_valid_d = (state_d == MP_HDR);
    np_valid_d = (state_d == NP_HDR);
    mode_out_d = (state_d == MODE_TX) ? mode_q[cnt_d[0]] : 1'b0;
    mp_out_d   = (state_d == MP_TX) ? mp_bits : 6'b0;
    np_out_d   = (state_d == NP_TX) ? np_bits : 2'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mp_sent_q  <= 1'b0;
      mode_q     <= 2'b00;
      mp_valid_q <= 1'b0;
      np_valid_q <= 1'b0;
      mode_out_q <= 1'b0;
      mp_out_q   <= 6'b0;
      np_out_q   <= 2'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mp_sent_q  <= mp_sent_d;
      mode_q     <= mode_d;
      mp_valid_q <= mp_valid_d;
      np_valid_q <= np_valid_d;
      mode_out_q <= mode_out_d;
      mp_out_q   <= mp_out_d;
      np_out_q   <= np_out_d;
    end
  end

  assign o_m_P_valid = mp_valid_q;
  assign o_mode      = mode_out_q;
  assign o_a         = mp_out_q[5];
  assign o_b         = mp_out_q[4];
  assign o_prime     = mp_out_q[3];
  assign o_Px        = mp_out_q[2];
  assign o_Py        = mp_out_q[1];
  assign o_m         = mp_out_q[0];
  assign o_nP_valid  = np_valid_q;
  assign o_nPx       = np_out_q[1];
  assign o_nPy       = np_out_q[0];

endmodule
